us_cmd_dispatch: RTL and testbench
==================================

US_CMD_DISPATCH -- requirements
Module: us_cmd_dispatch

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk  input  1  system clock (all logic on rising edge); rst  input  1  synchronous active-high reset.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning the maximum cycles to wait for tx_done_i before abandoning a command.
REQ-003 The block SHALL have these FIFO ports: fifo_empty_i  input  1  upstream command FIFO empty; fifo_dout_i  input  128  command word (standard FIFO, data valid 1 cycle after fifo_rd_en_o); fifo_rd_en_o  output  1  pop strobe.
REQ-004 The block SHALL have these TX engine ports: tx_req_o  output  1  request valid; tx_ack_i  input  1  engine accepted request; tx_done_i  input  1  engine finished TLP; tx_type_o  output  2  command type; tx_addr_o  output  32  WR32 target address; tx_dw_cnt_o  output  10  payload DWORDs; tx_cpl_hdr_o  output  62  CPLD header fields; tx_cpl_data_o  output  32  CPLD data.
REQ-005 The block SHALL have these status ports: up_wr_cmd_compl_o  output  1  WR32 finished pulse; cmd_id_o  output  2  ID of finished WR32; compl_done_o  output  1  CPLD finished pulse; err_o  output  1  bad command or timeout pulse; busy_o  output  1  not IDLE.

Function
REQ-006 Command field decode SHALL be: [63:62] type (WR32=2'b01, CPLD=2'b10, others reserved); WR32: [61:57] len, [56:55] cmd_id, [31:0] addr; CPLD: [61:0] header {tc,td,ep,attr,len,rid,tag,be,addr[6:0]}, [95:64] data.
REQ-007 The FSM SHALL have states IDLE, POP, LATCH, ISSUE, WAIT_DONE, NOTIFY.
REQ-008 In IDLE with fifo_empty_i=0, the FSM SHALL assert fifo_rd_en_o for exactly one cycle and go to POP; fifo_rd_en_o SHALL never assert while fifo_empty_i=1.
REQ-009 POP SHALL advance unconditionally to LATCH; LATCH SHALL register fifo_dout_i into output holding registers.
REQ-010 In LATCH, a reserved type, or WR32 len outside 2..7, SHALL pulse err_o for 1 cycle and return to IDLE without a TX request.
REQ-011 For WR32, tx_dw_cnt_o SHALL equal (1<<len)>>2 (len=7 gives 32); for CPLD, tx_dw_cnt_o SHALL equal 1.
REQ-012 In ISSUE, tx_req_o SHALL be held high with stable fields until the cycle tx_ack_i=1, then deassert next cycle; the FSM SHALL then enter WAIT_DONE.
REQ-013 WAIT_DONE SHALL count cycles from 0; tx_done_i=1 SHALL go to NOTIFY; reaching TIMEOUT_CYCLES-1 without tx_done_i SHALL pulse err_o and return to IDLE with no completion pulse.
REQ-014 NOTIFY SHALL last one cycle: WR32 pulses up_wr_cmd_compl_o with cmd_id_o = latched cmd_id; CPLD pulses compl_done_o; then return to IDLE.
REQ-015 tx_done_i in the same cycle as tx_ack_i SHALL be honoured, going directly to NOTIFY.
REQ-016 tx_done_i or tx_ack_i outside ISSUE/WAIT_DONE SHALL be ignored.
REQ-017 Back-to-back commands SHALL take at least 5 cycles each (IDLE, POP, LATCH, ISSUE, NOTIFY); commands SHALL be processed strictly in FIFO order, one outstanding at a time.
REQ-018 cmd_id_o SHALL hold its value between pulses; busy_o SHALL be 1 in every state but IDLE.

Reset
REQ-019 rst=1 SHALL force IDLE and zero every output and the timeout counter on the next clock edge.
REQ-020 Reset during ISSUE/WAIT_DONE SHALL abandon the command with no completion or err pulse; the popped word SHALL NOT be re-read.

Structure
REQ-021 Command type codes, field bit positions, and the len range 2..7 SHALL be defined in the shared include param.v (US_CMD_WR32_TYPE, US_CMD_CPLD_TYPE).
REQ-022 The block SHALL be a single module with no sub-modules; the timeout counter SHALL be inline.

Verification
REQ-023 WR32 with len=7, cmd_id=1, addr=0x12345678; tx_ack_i after 3 cycles, tx_done_i after 10 -> tx_dw_cnt_o=32, tx_addr_o=0x12345678, one up_wr_cmd_compl_o pulse with cmd_id_o=1.
REQ-024 CPLD with tag=5, be=0x0F, len=1, data=0xDEADBEEF -> tx_cpl_hdr_o matches input bits [61:0], tx_cpl_data_o=0xDEADBEEF, one compl_done_o pulse, no up_wr_cmd_compl_o.
REQ-025 Type=2'b11, then WR32 len=9 -> two err_o pulses, tx_req_o never asserted, FIFO popped twice.
REQ-026 TIMEOUT_CYCLES=16, tx_done_i withheld -> err_o pulse 16 cycles after WAIT_DONE entry, then next queued command served normally.
REQ-027 Four queued commands with tx_ack_i and tx_done_i tied high -> four completions in FIFO order, 5 cycles apart; fifo_rd_en_o never high while fifo_empty_i=1.
REQ-028 rst asserted in WAIT_DONE -> all outputs 0 next cycle, no completion pulse, IDLE resumes from the next FIFO word.

Source files
------------

// File: rtl/us_cmd_dispatch_pkg.sv
// Shared definitions for the upstream command dispatcher: command type codes,
// command-word field positions, legal WR32 length range and FSM state encoding.
package us_cmd_dispatch_pkg;

    localparam logic [1:0] US_CMD_WR32_TYPE = 2'b01;
    localparam logic [1:0] US_CMD_CPLD_TYPE = 2'b10;

    localparam int CMD_TYPE_HI = 63;
    localparam int CMD_TYPE_LO = 62;
    localparam int WR_LEN_HI   = 61;
    localparam int WR_LEN_LO   = 57;
    localparam int WR_ID_HI    = 56;
    localparam int WR_ID_LO    = 55;
    localparam int WR_ADDR_HI  = 31;
    localparam int WR_ADDR_LO  = 0;
    localparam int CPL_HDR_HI  = 61;
    localparam int CPL_HDR_LO  = 0;
    localparam int CPL_DATA_HI = 95;
    localparam int CPL_DATA_LO = 64;

    // WR32 len is log2 of the payload size in bytes; 4..128 bytes is legal
    localparam logic [4:0] WR_LEN_MIN = 5'd2;
    localparam logic [4:0] WR_LEN_MAX = 5'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POP,
        ST_LATCH,
        ST_ISSUE,
        ST_WAIT_DONE,
        ST_NOTIFY
    } state_t;

    function automatic logic wr32_len_ok(input logic [4:0] len);
        return (len >= WR_LEN_MIN) && (len <= WR_LEN_MAX);
    endfunction

    // payload DWORDs = bytes / 4, only meaningful for a legal len
    function automatic logic [9:0] wr32_dw_cnt(input logic [4:0] len);
        return 10'((32'd1 << len) >> 2);
    endfunction

endpackage

// File: rtl/us_cmd_dispatch.sv
// Upstream command dispatcher: pops one command word at a time from the
// command FIFO, decodes it, hands it to the TX engine and reports completion,
// rejection or timeout. Only one command is ever outstanding.
module us_cmd_dispatch
    import us_cmd_dispatch_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         fifo_empty_i,
    input  logic [127:0] fifo_dout_i,
    output logic         fifo_rd_en_o,
    output logic         tx_req_o,
    input  logic         tx_ack_i,
    input  logic         tx_done_i,
    output logic [1:0]   tx_type_o,
    output logic [31:0]  tx_addr_o,
    output logic [9:0]   tx_dw_cnt_o,
    output logic [61:0]  tx_cpl_hdr_o,
    output logic [31:0]  tx_cpl_data_o,
    output logic         up_wr_cmd_compl_o,
    output logic [1:0]   cmd_id_o,
    output logic         compl_done_o,
    output logic         err_o,
    output logic         busy_o
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] to_cnt;
    logic             is_wr_q;
    logic [1:0]       wr_id_q;

    logic [1:0] cmd_type;
    logic [4:0] wr_len;
    logic [1:0] wr_id;
    logic       unused_bits;

    assign cmd_type    = fifo_dout_i[CMD_TYPE_HI:CMD_TYPE_LO];
    assign wr_len      = fifo_dout_i[WR_LEN_HI:WR_LEN_LO];
    assign wr_id       = fifo_dout_i[WR_ID_HI:WR_ID_LO];
    assign unused_bits = ^fifo_dout_i[127:96];

    // Dispatch FSM; every output is registered and pulses default low each cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= ST_IDLE;
            to_cnt            <= '0;
            is_wr_q           <= 1'b0;
            wr_id_q           <= '0;
            fifo_rd_en_o      <= 1'b0;
            tx_req_o          <= 1'b0;
            tx_type_o         <= '0;
            tx_addr_o         <= '0;
            tx_dw_cnt_o       <= '0;
            tx_cpl_hdr_o      <= '0;
            tx_cpl_data_o     <= '0;
            up_wr_cmd_compl_o <= 1'b0;
            cmd_id_o          <= '0;
            compl_done_o      <= 1'b0;
            err_o             <= 1'b0;
            busy_o            <= 1'b0;
        end else begin
            fifo_rd_en_o      <= 1'b0;
            up_wr_cmd_compl_o <= 1'b0;
            compl_done_o      <= 1'b0;
            err_o             <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty_i) begin
                        fifo_rd_en_o <= 1'b1;
                        busy_o       <= 1'b1;
                        state        <= ST_POP;
                    end
                end
                ST_POP: begin
                    // FIFO data appears the cycle after the pop strobe
                    state <= ST_LATCH;
                end
                ST_LATCH: begin
                    tx_type_o     <= cmd_type;
                    tx_addr_o     <= fifo_dout_i[WR_ADDR_HI:WR_ADDR_LO];
                    tx_cpl_hdr_o  <= fifo_dout_i[CPL_HDR_HI:CPL_HDR_LO];
                    tx_cpl_data_o <= fifo_dout_i[CPL_DATA_HI:CPL_DATA_LO];
                    is_wr_q       <= (cmd_type == US_CMD_WR32_TYPE);
                    wr_id_q       <= wr_id;
                    if (cmd_type == US_CMD_WR32_TYPE && wr32_len_ok(wr_len)) begin
                        tx_dw_cnt_o <= wr32_dw_cnt(wr_len);
                        tx_req_o    <= 1'b1;
                        state       <= ST_ISSUE;
                    end else if (cmd_type == US_CMD_CPLD_TYPE) begin
                        tx_dw_cnt_o <= 10'd1;
                        tx_req_o    <= 1'b1;
                        state       <= ST_ISSUE;
                    end else begin
                        tx_dw_cnt_o <= '0;
                        err_o       <= 1'b1;
                        busy_o      <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    if (tx_ack_i) begin
                        tx_req_o <= 1'b0;
                        to_cnt   <= '0;
                        // a done that arrives with the ack skips the wait
                        if (tx_done_i) begin
                            if (is_wr_q) begin
                                up_wr_cmd_compl_o <= 1'b1;
                                cmd_id_o          <= wr_id_q;
                            end else begin
                                compl_done_o <= 1'b1;
                            end
                            state <= ST_NOTIFY;
                        end else begin
                            state <= ST_WAIT_DONE;
                        end
                    end
                end
                ST_WAIT_DONE: begin
                    if (tx_done_i) begin
                        if (is_wr_q) begin
                            up_wr_cmd_compl_o <= 1'b1;
                            cmd_id_o          <= wr_id_q;
                        end else begin
                            compl_done_o <= 1'b1;
                        end
                        state <= ST_NOTIFY;
                    end else if (to_cnt == CNT_LAST) begin
                        err_o  <= 1'b1;
                        busy_o <= 1'b0;
                        state  <= ST_IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                ST_NOTIFY: begin
                    busy_o <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    busy_o <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_us_cmd_dispatch.sv
// Directed testbench for us_cmd_dispatch with a small FIFO model, a TX engine
// model with programmable ack/done latency and a pulse monitor.
module tb_us_cmd_dispatch;

    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         fifo_empty_i;
    logic [127:0] fifo_dout_i = '0;
    logic         fifo_rd_en_o;
    logic         tx_req_o;
    logic         tx_ack_i = 1'b0;
    logic         tx_done_i = 1'b0;
    logic [1:0]   tx_type_o;
    logic [31:0]  tx_addr_o;
    logic [9:0]   tx_dw_cnt_o;
    logic [61:0]  tx_cpl_hdr_o;
    logic [31:0]  tx_cpl_data_o;
    logic         up_wr_cmd_compl_o;
    logic [1:0]   cmd_id_o;
    logic         compl_done_o;
    logic         err_o;
    logic         busy_o;

    int n_chk = 0;
    int n_fail = 0;

    us_cmd_dispatch #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .fifo_empty_i(fifo_empty_i), .fifo_dout_i(fifo_dout_i), .fifo_rd_en_o(fifo_rd_en_o),
        .tx_req_o(tx_req_o), .tx_ack_i(tx_ack_i), .tx_done_i(tx_done_i),
        .tx_type_o(tx_type_o), .tx_addr_o(tx_addr_o), .tx_dw_cnt_o(tx_dw_cnt_o),
        .tx_cpl_hdr_o(tx_cpl_hdr_o), .tx_cpl_data_o(tx_cpl_data_o),
        .up_wr_cmd_compl_o(up_wr_cmd_compl_o), .cmd_id_o(cmd_id_o),
        .compl_done_o(compl_done_o), .err_o(err_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    // FIFO model: words written by the stimulus tasks, popped on rd_en
    logic [127:0] mem [0:63];
    int wr_cnt = 0;
    int rd_cnt = 0;
    int rd_viol = 0;
    assign fifo_empty_i = (wr_cnt == rd_cnt);

    always @(posedge clk) begin
        if (fifo_rd_en_o) begin
            if (wr_cnt == rd_cnt) rd_viol <= rd_viol + 1;
            else begin
                fifo_dout_i <= mem[rd_cnt % 64];
                rd_cnt      <= rd_cnt + 1;
            end
        end
    end

    // TX engine model: ack ack_dly cycles into the request, done done_dly
    // cycles after the ack (never if negative), or both tied high
    logic eng_tie = 1'b0;
    int ack_dly = 0;
    int done_dly = 0;
    int eng_phase = 0;
    int eng_k = 0;

    always @(negedge clk) begin
        if (eng_tie) begin
            tx_ack_i = 1'b1; tx_done_i = 1'b1; eng_phase = 0;
        end else begin
            tx_ack_i = 1'b0; tx_done_i = 1'b0;
            case (eng_phase)
                0: if (tx_req_o) begin
                    if (ack_dly == 0) begin tx_ack_i = 1'b1; eng_phase = 2; eng_k = 0; end
                    else begin eng_phase = 1; eng_k = 1; end
                end
                1: if (!busy_o) eng_phase = 0;
                   else if (eng_k == ack_dly) begin tx_ack_i = 1'b1; eng_phase = 2; eng_k = 0; end
                   else eng_k++;
                2: if (!busy_o) eng_phase = 0;
                   else if (done_dly >= 0 && eng_k == done_dly) begin tx_done_i = 1'b1; eng_phase = 0; end
                   else eng_k++;
                default: eng_phase = 0;
            endcase
        end
    end

    // Pulse monitor, sampled shortly after each rising edge
    int cyc = 0;
    int n_err = 0, n_wr = 0, n_cpl = 0, n_req = 0, n_pop = 0;
    int last_err_cyc = 0, last_req_cyc = 0;
    logic [1:0] id_log[$];
    int wr_cyc[$];

    always begin
        @(posedge clk);
        #2;
        cyc++;
        if (err_o) begin n_err++; last_err_cyc = cyc; end
        if (up_wr_cmd_compl_o) begin n_wr++; id_log.push_back(cmd_id_o); wr_cyc.push_back(cyc); end
        if (compl_done_o) n_cpl++;
        if (tx_req_o) begin n_req++; last_req_cyc = cyc; end
        if (fifo_rd_en_o) n_pop++;
    end

    function automatic logic [127:0] mk_wr(input logic [4:0] len, input logic [1:0] id, input logic [31:0] addr);
        logic [127:0] w;
        w = '0;
        w[127:96] = 32'hA5A5_5A5A;
        w[63:62] = 2'b01;
        w[61:57] = len;
        w[56:55] = id;
        w[31:0]  = addr;
        return w;
    endfunction

    function automatic logic [127:0] mk_cpl(input logic [61:0] hdr, input logic [31:0] data);
        logic [127:0] w;
        w = '0;
        w[63:62] = 2'b10;
        w[61:0]  = hdr;
        w[95:64] = data;
        return w;
    endfunction

    task automatic push(input logic [127:0] w);
        mem[wr_cnt % 64] = w;
        wr_cnt = wr_cnt + 1;
    endtask

    task automatic settle();
        for (int i = 0; i < 60 && busy_o; i++) @(negedge clk);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({fifo_rd_en_o, tx_req_o, up_wr_cmd_compl_o, compl_done_o, err_o, busy_o} !== 6'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 000000",
                {fifo_rd_en_o, tx_req_o, up_wr_cmd_compl_o, compl_done_o, err_o, busy_o});
        end
        n_chk++;
        if ({tx_type_o, tx_addr_o, tx_dw_cnt_o, tx_cpl_hdr_o, tx_cpl_data_o, cmd_id_o} !== '0) begin
            n_fail++; $display("FAIL reset_data: addr=%h dw=%0d hdr=%h data=%h want all 0",
                tx_addr_o, tx_dw_cnt_o, tx_cpl_hdr_o, tx_cpl_data_o);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_chk++;
        if (busy_o !== 1'b0 || fifo_rd_en_o !== 1'b0) begin
            n_fail++; $display("FAIL idle_empty: busy=%b rd_en=%b want 0 0", busy_o, fifo_rd_en_o);
        end
    endtask

    task automatic test_wr32();
        int s_wr, s_err, s_cpl, s_req;
        bit seen;
        s_wr = n_wr; s_err = n_err; s_cpl = n_cpl; s_req = n_req; seen = 0;
        ack_dly = 3; done_dly = 10;
        push(mk_wr(5'd7, 2'd1, 32'h1234_5678));
        for (int i = 0; i < 100 && n_wr == s_wr; i++) begin
            @(negedge clk);
            if (tx_req_o && !seen) begin
                seen = 1;
                n_chk++;
                if (tx_dw_cnt_o !== 10'd32 || tx_addr_o !== 32'h1234_5678 || tx_type_o !== 2'b01) begin
                    n_fail++; $display("FAIL wr32_fields: dw=%0d addr=%h type=%b want 32 12345678 01",
                        tx_dw_cnt_o, tx_addr_o, tx_type_o);
                end
            end
        end
        n_chk++;
        if (n_wr - s_wr != 1 || id_log.size() == 0) begin
            n_fail++; $display("FAIL wr32_compl: got %0d completions want 1", n_wr - s_wr);
        end else if (id_log[$] !== 2'd1) begin
            n_fail++; $display("FAIL wr32_compl: cmd_id=%0d want 1", id_log[$]);
        end
        n_chk++;
        if (n_req - s_req != 4) begin
            n_fail++; $display("FAIL wr32_req_len: req high %0d cycles want 4", n_req - s_req);
        end
        repeat (3) @(negedge clk);
        n_chk++;
        if (cmd_id_o !== 2'd1 || up_wr_cmd_compl_o !== 1'b0 || busy_o !== 1'b0) begin
            n_fail++; $display("FAIL wr32_hold: id=%0d pulse=%b busy=%b want 1 0 0",
                cmd_id_o, up_wr_cmd_compl_o, busy_o);
        end
        n_chk++;
        if (n_err != s_err || n_cpl != s_cpl) begin
            n_fail++; $display("FAIL wr32_extra: err=%0d cpl=%0d want 0 0", n_err - s_err, n_cpl - s_cpl);
        end
    endtask

    task automatic test_cpld();
        logic [61:0] hdr;
        int s_wr, s_cpl, s_err;
        bit seen;
        hdr = 62'h2A5A_0040_1234_0587;
        s_wr = n_wr; s_cpl = n_cpl; s_err = n_err; seen = 0;
        ack_dly = 0; done_dly = 2;
        push(mk_cpl(hdr, 32'hDEAD_BEEF));
        for (int i = 0; i < 60 && n_cpl == s_cpl; i++) begin
            @(negedge clk);
            if (tx_req_o && !seen) begin
                seen = 1;
                n_chk++;
                if (tx_cpl_hdr_o !== hdr || tx_cpl_data_o !== 32'hDEAD_BEEF || tx_dw_cnt_o !== 10'd1 || tx_type_o !== 2'b10) begin
                    n_fail++; $display("FAIL cpld_fields: hdr=%h data=%h dw=%0d type=%b want %h deadbeef 1 10",
                        tx_cpl_hdr_o, tx_cpl_data_o, tx_dw_cnt_o, tx_type_o, hdr);
                end
            end
        end
        n_chk++;
        if (n_cpl - s_cpl != 1 || n_wr != s_wr || n_err != s_err) begin
            n_fail++; $display("FAIL cpld_compl: cpl=%0d wr=%0d err=%0d want 1 0 0",
                n_cpl - s_cpl, n_wr - s_wr, n_err - s_err);
        end
        settle();
    endtask

    task automatic test_bad_cmds();
        logic [127:0] w;
        int s_err, s_req, s_pop;
        s_err = n_err; s_req = n_req; s_pop = n_pop;
        w = mk_wr(5'd3, 2'd0, 32'h0);
        w[63:62] = 2'b11;
        push(w);
        push(mk_wr(5'd9, 2'd2, 32'h0000_1000));
        push(mk_wr(5'd1, 2'd3, 32'h0000_2000));
        repeat (20) @(negedge clk);
        n_chk++;
        if (n_err - s_err != 3) begin
            n_fail++; $display("FAIL bad_err: got %0d err pulses want 3", n_err - s_err);
        end
        n_chk++;
        if (n_req != s_req) begin
            n_fail++; $display("FAIL bad_req: tx_req high %0d cycles want 0", n_req - s_req);
        end
        n_chk++;
        if (n_pop - s_pop != 3 || busy_o !== 1'b0) begin
            n_fail++; $display("FAIL bad_pop: pops=%0d busy=%b want 3 0", n_pop - s_pop, busy_o);
        end
    endtask

    task automatic test_timeout();
        int s_err, s_wr, s_cpl, e, r;
        s_err = n_err; s_wr = n_wr; s_cpl = n_cpl;
        ack_dly = 0; done_dly = -1;
        push(mk_wr(5'd3, 2'd2, 32'h0000_4000));
        push(mk_cpl(62'h1, 32'h0000_0055));
        for (int i = 0; i < 60 && n_err == s_err; i++) @(negedge clk);
        e = last_err_cyc; r = last_req_cyc;
        done_dly = 2;
        n_chk++;
        if (n_err - s_err != 1) begin
            n_fail++; $display("FAIL timeout_err: got %0d err pulses want 1", n_err - s_err);
        end
        n_chk++;
        if (e - r != TO + 1) begin
            n_fail++; $display("FAIL timeout_lat: err %0d cycles after ack want %0d", e - r, TO + 1);
        end
        for (int i = 0; i < 40 && n_cpl == s_cpl; i++) @(negedge clk);
        n_chk++;
        if (n_cpl - s_cpl != 1 || n_wr != s_wr || n_err - s_err != 1) begin
            n_fail++; $display("FAIL timeout_next: cpl=%0d wr=%0d err=%0d want 1 0 1",
                n_cpl - s_cpl, n_wr - s_wr, n_err - s_err);
        end
        settle();
    endtask

    task automatic test_back_to_back();
        int s, s_wr;
        s = wr_cyc.size(); s_wr = n_wr;
        eng_tie = 1'b1;
        for (int i = 0; i < 4; i++) push(mk_wr(5'd2 + 5'(i), 2'(i), 32'h100 * i));
        for (int i = 0; i < 80 && n_wr < s_wr + 4; i++) @(negedge clk);
        n_chk++;
        if (n_wr - s_wr != 4) begin
            n_fail++; $display("FAIL b2b_count: got %0d completions want 4", n_wr - s_wr);
        end
        for (int i = 0; i < 4 && s + i < id_log.size(); i++) begin
            n_chk++;
            if (id_log[s + i] !== 2'(i)) begin
                n_fail++; $display("FAIL b2b_order: completion %0d id=%0d want %0d", i, id_log[s + i], i);
            end
        end
        for (int i = 1; i < 4 && s + i < wr_cyc.size(); i++) begin
            n_chk++;
            if (wr_cyc[s + i] - wr_cyc[s + i - 1] != 5) begin
                n_fail++; $display("FAIL b2b_spacing: gap %0d cycles want 5", wr_cyc[s + i] - wr_cyc[s + i - 1]);
            end
        end
        eng_tie = 1'b0;
        settle();
        n_chk++;
        if (rd_viol != 0) begin
            n_fail++; $display("FAIL rd_en_empty: %0d pops while empty want 0", rd_viol);
        end
    endtask

    task automatic test_reset_wait();
        int s_req, s_wr, s_err, s_pop;
        s_req = n_req; s_wr = n_wr; s_err = n_err; s_pop = n_pop;
        ack_dly = 0; done_dly = -1;
        push(mk_wr(5'd4, 2'd2, 32'h0000_8000));
        push(mk_wr(5'd5, 2'd3, 32'h0000_9000));
        for (int i = 0; i < 20 && n_req == s_req; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_chk++;
        if ({fifo_rd_en_o, tx_req_o, tx_type_o, tx_addr_o, tx_dw_cnt_o, tx_cpl_hdr_o, tx_cpl_data_o,
             up_wr_cmd_compl_o, cmd_id_o, compl_done_o, err_o, busy_o} !== '0) begin
            n_fail++; $display("FAIL rst_wait_outs: busy=%b addr=%h dw=%0d id=%0d want all 0",
                busy_o, tx_addr_o, tx_dw_cnt_o, cmd_id_o);
        end
        done_dly = 2;
        rst = 1'b0;
        for (int i = 0; i < 40 && n_wr == s_wr; i++) @(negedge clk);
        n_chk++;
        if (n_wr - s_wr != 1 || id_log.size() == 0) begin
            n_fail++; $display("FAIL rst_wait_resume: got %0d completions want 1", n_wr - s_wr);
        end else if (id_log[$] !== 2'd3) begin
            n_fail++; $display("FAIL rst_wait_resume: cmd_id=%0d want 3", id_log[$]);
        end
        n_chk++;
        if (n_pop - s_pop != 2 || n_err != s_err) begin
            n_fail++; $display("FAIL rst_wait_pops: pops=%0d err=%0d want 2 0", n_pop - s_pop, n_err - s_err);
        end
        settle();
    endtask

    initial begin
        test_reset();
        test_wr32();
        test_cpld();
        test_bad_cmds();
        test_timeout();
        test_back_to_back();
        test_reset_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
